// File: rtl/des3_equiv_checker.sv
// On-chip equivalence checker for a reference and a locked DES3 pair.
// It captures the first output of each side, compares them, and keeps saturating pass/fail statistics.
module des3_equiv_checker #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      desOut_orig,
  input  logic             out_valid_orig,
  input  logic [63:0]      desOut_lbll,
  input  logic             out_valid_lbll,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic             busy,
  output logic             err_sticky,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [63:0]      first_err_xor
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REPORT} state_t;

  state_t        state;
  logic          got_o, got_l;
  logic [63:0]   data_o, data_l;
  logic [TW-1:0] timer;

  logic        cap_o, cap_l, nxt_got_o, nxt_got_l, both, resolve, same;
  logic [63:0] nxt_o, nxt_l;

  // Resolution looks at this cycle's captures, so simultaneous valids resolve immediately
  always_comb begin
    cap_o     = out_valid_orig && !got_o;
    cap_l     = out_valid_lbll && !got_l;
    nxt_got_o = got_o || out_valid_orig;
    nxt_got_l = got_l || out_valid_lbll;
    nxt_o     = cap_o ? desOut_orig : data_o;
    nxt_l     = cap_l ? desOut_lbll : data_l;
    both      = nxt_got_o && nxt_got_l;
    same      = (nxt_o == nxt_l);
    resolve   = both || (timer == TMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      got_o         <= 1'b0;
      got_l         <= 1'b0;
      data_o        <= '0;
      data_l        <= '0;
      timer         <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= 2'd0;
      busy          <= 1'b0;
      err_sticky    <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_xor <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= WAIT;
            busy   <= 1'b1;
            got_o  <= 1'b0;
            got_l  <= 1'b0;
            data_o <= '0;
            data_l <= '0;
            timer  <= '0;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (cap_o) begin
            got_o  <= 1'b1;
            data_o <= desOut_orig;
          end
          if (cap_l) begin
            got_l  <= 1'b1;
            data_l <= desOut_lbll;
          end
          if (resolve) begin
            state <= REPORT;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= both && same;
            if (both)                        fail_code <= same ? 2'd0 : 2'd1;
            else if (nxt_got_o || nxt_got_l) fail_code <= 2'd2;
            else                             fail_code <= 2'd3;
          end
        end
        REPORT: begin
          done  <= 1'b0;
          state <= IDLE;
          if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_W'(1);
          if (!pass && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          // Only a data mismatch has a meaningful difference pattern
          if (!pass && !err_sticky) begin
            err_sticky    <= 1'b1;
            first_err_xor <= (fail_code == 2'd1) ? (data_o ^ data_l) : '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des3_equiv_checker.sv
// Directed bench for des3_equiv_checker: a TIMEOUT=8 instance plus a CNT_W=2 copy on the same stimulus for saturation.
module tb_des3_equiv_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        vo = 1'b0, vl = 1'b0;
  logic [63:0] d_orig = '0, d_lbll = '0;

  logic        done, pass, busy, err_sticky;
  logic [1:0]  fail_code;
  logic [15:0] vec_cnt, err_cnt;
  logic [63:0] first_err_xor;

  logic        s_done, s_pass, s_busy, s_sticky;
  logic [1:0]  s_code;
  logic [1:0]  s_vec, s_err;
  logic [63:0] s_xor;

  des3_equiv_checker #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .desOut_orig(d_orig), .out_valid_orig(vo),
    .desOut_lbll(d_lbll), .out_valid_lbll(vl),
    .done(done), .pass(pass), .fail_code(fail_code), .busy(busy),
    .err_sticky(err_sticky), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_xor(first_err_xor)
  );

  des3_equiv_checker #(.TIMEOUT(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .desOut_orig(d_orig), .out_valid_orig(vo),
    .desOut_lbll(d_lbll), .out_valid_lbll(vl),
    .done(s_done), .pass(s_pass), .fail_code(s_code), .busy(s_busy),
    .err_sticky(s_sticky), .vec_cnt(s_vec), .err_cnt(s_err),
    .first_err_xor(s_xor)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int ndone, nbusy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // co/cl: WAIT cycle of orig/lbll valid; co2: extra orig valid carrying d_o2; sa: WAIT cycle of a stray start.
  // lat counts cycles from the start cycle to the cycle where done is seen.
  task automatic run_vec(input int co, input int cl, input int co2, input int sa,
                         input logic [63:0] d_o, input logic [63:0] d_l, input logic [63:0] d_o2,
                         input bit pre, output int lt);
    int i;
    start = 1'b1; vo = pre; vl = pre; d_orig = ~d_o; d_lbll = d_l ^ 64'h5A;
    step();
    start = 1'b0; vo = 1'b0; vl = 1'b0;
    lt = 1; i = 0;
    while (!done && lt < 40) begin
      vo     = (i == co) || (i == co2);
      d_orig = (i == co2) ? d_o2 : d_o;
      vl     = (i == cl);
      d_lbll = d_l;
      start  = (i == sa);
      step();
      lt++; i++;
    end
    vo = 1'b0; vl = 1'b0; start = 1'b0;
    if (!done) chk("done_wait_bound", 64'(done), 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_code"}, 64'(fail_code), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sticky"}, 64'(err_sticky), 64'd0);
    chk({tag, "_vec"}, 64'(vec_cnt), 64'd0);
    chk({tag, "_err"}, 64'(err_cnt), 64'd0);
    chk({tag, "_xor"}, first_err_xor, 64'd0);
  endtask

  initial begin
    step(); step(); step();
    rst = 1'b0;
    chk_reset_state("rst");

    // match, valids 5 cycles into WAIT
    run_vec(5, 5, -1, -1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, '0, 1'b0, lat);
    chk("match_lat", 64'(lat), 64'd7);
    chk("match_pass", 64'(pass), 64'd1);
    chk("match_code", 64'(fail_code), 64'd0);
    step();
    chk("match_done_low", 64'(done), 64'd0);
    chk("match_pass_hold", 64'(pass), 64'd1);
    chk("match_vec", 64'(vec_cnt), 64'd1);
    chk("match_err", 64'(err_cnt), 64'd0);
    chk("match_sticky", 64'(err_sticky), 64'd0);

    // minimum latency
    run_vec(0, 0, -1, -1, 64'hCAFE, 64'hCAFE, '0, 1'b0, lat);
    chk("min_lat", 64'(lat), 64'd2);
    chk("min_pass", 64'(pass), 64'd1);
    step();
    chk("min_vec", 64'(vec_cnt), 64'd2);

    // first data mismatch
    run_vec(0, 0, -1, -1, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0001, '0, 1'b0, lat);
    chk("mis_lat", 64'(lat), 64'd2);
    chk("mis_pass", 64'(pass), 64'd0);
    chk("mis_code", 64'(fail_code), 64'd1);
    step();
    chk("mis_sticky", 64'(err_sticky), 64'd1);
    chk("mis_xor", first_err_xor, 64'h1);
    chk("mis_vec", 64'(vec_cnt), 64'd3);
    chk("mis_err", 64'(err_cnt), 64'd1);

    // later mismatch must not reload first_err_xor
    run_vec(2, 2, -1, -1, 64'h5, 64'hA, '0, 1'b0, lat);
    chk("mis2_lat", 64'(lat), 64'd4);
    chk("mis2_code", 64'(fail_code), 64'd1);
    step();
    chk("mis2_xor", first_err_xor, 64'h1);
    chk("mis2_err", 64'(err_cnt), 64'd2);

    // staggered valids with a second orig valid that must be ignored
    run_vec(1, 4, 2, -1, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444,
            64'hDEAD_BEEF_DEAD_BEEF, 1'b0, lat);
    chk("stag_lat", 64'(lat), 64'd6);
    chk("stag_pass", 64'(pass), 64'd1);
    chk("stag_code", 64'(fail_code), 64'd0);
    step();
    chk("stag_vec", 64'(vec_cnt), 64'd5);

    // both valids on the last WAIT cycle still count as captured
    run_vec(7, 7, -1, -1, 64'h77, 64'h77, '0, 1'b0, lat);
    chk("last_lat", 64'(lat), 64'd9);
    chk("last_pass", 64'(pass), 64'd1);
    step();

    // stray start during WAIT: one done only
    run_vec(3, 3, -1, 1, 64'hB0B0, 64'hB0B0, '0, 1'b0, lat);
    chk("sw_lat", 64'(lat), 64'd5);
    step();
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 12; k++) begin
      ndone += int'(done);
      nbusy += int'(busy);
      step();
    end
    chk("sw_extra_done", 64'(ndone), 64'd0);
    chk("sw_extra_busy", 64'(nbusy), 64'd0);
    chk("sw_vec", 64'(vec_cnt), 64'd7);
    chk("sw_err", 64'(err_cnt), 64'd2);

    // reset mid-WAIT aborts the vector
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rw_busy", 64'(busy), 64'd1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rw");
    vo = 1'b1; vl = 1'b1; d_orig = 64'h1; d_lbll = 64'h2;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      ndone += int'(done);
    end
    vo = 1'b0; vl = 1'b0;
    chk("rw_no_done", 64'(ndone), 64'd0);
    chk("rw_idle_vec", 64'(vec_cnt), 64'd0);

    // skew: only orig valid
    run_vec(0, -1, -1, -1, 64'h1234, 64'h1234, '0, 1'b0, lat);
    chk("skew_lat", 64'(lat), 64'd9);
    chk("skew_pass", 64'(pass), 64'd0);
    chk("skew_code", 64'(fail_code), 64'd2);
    step();
    chk("skew_xor", first_err_xor, '1);
    chk("skew_sticky", 64'(err_sticky), 64'd1);
    chk("skew_err", 64'(err_cnt), 64'd1);

    // timeout; valids in the start (IDLE) cycle must be ignored
    run_vec(-1, -1, -1, -1, 64'h9, 64'h9, '0, 1'b1, lat);
    chk("to_lat", 64'(lat), 64'd9);
    chk("to_code", 64'(fail_code), 64'd3);
    step();
    chk("to_vec", 64'(vec_cnt), 64'd2);
    chk("to_err", 64'(err_cnt), 64'd2);

    // saturation of the CNT_W=2 copy
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sat_rst_vec", 64'(s_vec), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      run_vec(-1, -1, -1, -1, '0, '0, '0, 1'b0, lat);
      chk("sat_done", 64'(s_done), 64'd1);
      chk("sat_code", 64'(s_code), 64'd3);
      step();
      chk("sat_vec", 64'(s_vec), 64'((k > 3) ? 3 : k));
      chk("sat_err", 64'(s_err), 64'((k > 3) ? 3 : k));
    end
    run_vec(0, 0, -1, -1, 64'h42, 64'h42, '0, 1'b0, lat);
    chk("sat_pass", 64'(s_pass), 64'd1);
    step();
    chk("sat_vec_hold", 64'(s_vec), 64'd3);
    chk("sat_err_hold", 64'(s_err), 64'd3);
    chk("sat_sticky", 64'(s_sticky), 64'd1);
    chk("sat_xor", s_xor, '1);
    chk("sat_busy", 64'(s_busy), 64'd0);
    chk("sat_main_vec", 64'(vec_cnt), 64'd6);
    chk("sat_main_err", 64'(err_cnt), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/des3_equiv_checker.md
# des3_equiv_checker

Synthesizable on-chip equivalence checker that sits directly downstream of a reference `des3` instance and a locked `des3_MODE_NBITS` instance. Both instances share `desIn`, the keys and `decrypt`. For each vector it captures both `{out_valid, desOut}` streams and compares them, then reports pass/fail with a reason code. It keeps running statistics, so equivalence can be checked in emulation or silicon without a simulator scoreboard.

## Interface
Parameters:
- TIMEOUT, 64, WAIT cycles allowed per vector before forced resolution (>=2)
- CNT_W, 16, width of vector and error counters

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: new vector applied to both DUTs this cycle
- desOut_orig  in  64  reference DES3 output
- out_valid_orig  in  1  reference output valid
- desOut_lbll  in  64  locked DES3 output
- out_valid_lbll  in  1  locked output valid
- done  out  1  one-cycle pulse: vector resolved
- pass  out  1  valid with done; 1 = equivalent
- fail_code  out  2  valid with done: 0 ok, 1 data mismatch, 2 valid skew, 3 timeout (neither valid)
- busy  out  1  high in WAIT
- err_sticky  out  1  set on first failure, held until rst
- vec_cnt  out  CNT_W  resolved vectors, saturating
- err_cnt  out  CNT_W  failed vectors, saturating
- first_err_xor  out  64  desOut_orig ^ desOut_lbll of first failing vector; all-ones if that failure was skew or timeout

## Operation
- FSM states: IDLE, WAIT, REPORT.
- IDLE: `start` moves to WAIT. On entry, `got_o` and `got_l` clear, `timer` = 0, and the data registers clear.
- WAIT, each cycle:
  - If `out_valid_orig` and !`got_o`, capture `desOut_orig` and set `got_o`. `out_valid_lbll` is handled the same way for the locked side.
  - Only the first valid per side is captured; later valids are ignored.
  - `timer` increments.
- WAIT resolves when both sides are captured, counting captures made this cycle (so simultaneous valids resolve immediately). Otherwise it resolves when `timer` reaches TIMEOUT-1.
- On resolution, WAIT moves to REPORT and registers the result:
  - both captured, data equal: pass=1, code 0
  - both captured, data differ: code 1
  - exactly one side captured: code 2
  - neither side captured: code 3
- REPORT (one cycle):
  - `done` = 1.
  - `vec_cnt` += 1 and `err_cnt` += !`pass`; both saturate at all-ones.
  - On the first failure since reset, `first_err_xor` loads and `err_sticky` sets.
  - Next state is IDLE.
- `start` is ignored in WAIT and REPORT; it is not queued.
- Valids arriving in IDLE or REPORT are ignored.

## Timing
- Reset values: done=0, pass=0, fail_code=0, busy=0, err_sticky=0, vec_cnt=0, err_cnt=0, first_err_xor=0, state IDLE.
- Reset mid-WAIT aborts the vector: no `done` pulse and no counter update.
- `start` sampled at edge t puts the FSM in WAIT for cycle t+1; `busy` is high from t+1.
- If the last needed valid is sampled at edge k, REPORT occupies cycle k+1. `done`, `pass` and `fail_code` are high/valid that cycle, and counters show updated values from k+2.
- Minimum latency, with both valids in the first WAIT cycle: `done` appears 2 cycles after `start`.
- Timeout: WAIT lasts exactly TIMEOUT cycles, and `done` is asserted TIMEOUT+1 cycles after `start`.
- Earliest accepted next `start` is the cycle after REPORT.
- `pass` and `fail_code` hold their values until the next REPORT.
- Counters and the comparator are pure registered logic; no combinational path from inputs to outputs.

## Test plan
- Match: start, then 5 cycles later both valids with data 64'h0123_4567_89AB_CDEF -> done 1 cycle later, pass=1, code 0, vec_cnt=1, err_cnt=0.
- Data mismatch: orig 64'hFFFF_0000_FFFF_0000, lbll 64'hFFFF_0000_FFFF_0001 in the same cycle -> pass=0, code 1, err_sticky=1, first_err_xor=64'h1. A later mismatch leaves first_err_xor unchanged.
- Skew and timeout, TIMEOUT=8:
  - only orig valid -> done 9 cycles after start, code 2, first_err_xor all-ones.
  - no valids -> code 3.
- Staggered valids: orig at WAIT cycle 1, lbll at WAIT cycle 4, equal data -> pass. A second orig valid with different data at cycle 2 is ignored.
- Control corners:
  - start pulsed during WAIT -> ignored; exactly one done.
  - rst asserted mid-WAIT -> no done; all outputs return to reset values next cycle.
- Saturation, CNT_W=2: 5 failing vectors -> vec_cnt=3, err_cnt=3, both stay at 3.
